// File: rtl/parallel_macc_pkg.sv
// parallel_macc_pkg: shared width helpers and default formats for the neuron MAC datapath
package parallel_macc_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int PARALLEL_IN_DEF = 4;
  localparam int DATA1_WIDTH_DEF = 16;
  localparam int DATA1_INT_DEF = 2;
  localparam int DATA2_WIDTH_DEF = 16;
  localparam int DATA2_INT_DEF = 2;
  localparam int ACC_WIDTH_DEF = 20;
  localparam int DOUT_WIDTH_DEF = 32;
  localparam int DOUT_INT_DEF = 8;
  localparam int P_DEF = DATA1_WIDTH_DEF + DATA2_WIDTH_DEF;
  localparam int PF_DEF = P_DEF - DATA1_INT_DEF - DATA2_INT_DEF;
  localparam int S_DEF = P_DEF + clog2(PARALLEL_IN_DEF);
  localparam int A_DEF = S_DEF + ACC_WIDTH_DEF;
  localparam int DOUT_FRAC_DEF = DOUT_WIDTH_DEF - DOUT_INT_DEF;
endpackage

// File: rtl/parallel_macc_signed_cast_sat.sv
// signed_cast_sat: signed fixed-point realign with floor truncation and saturation
module signed_cast_sat #(
  parameter int IN_WIDTH = 54,
  parameter int IN_FRAC = 28,
  parameter int OUT_WIDTH = 32,
  parameter int OUT_FRAC = 24
) (
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] dout
);
  localparam int W = IN_WIDTH + OUT_WIDTH;
  logic signed [W-1:0] ext;
  logic signed [W-1:0] aligned;
  logic fits;
  assign ext = W'($signed(din));
  if (IN_FRAC >= OUT_FRAC) begin : g_trunc
    assign aligned = ext >>> (IN_FRAC - OUT_FRAC);
  end else begin : g_pad
    assign aligned = ext <<< (OUT_FRAC - IN_FRAC);
  end
  assign fits = (&aligned[W-1:OUT_WIDTH-1]) | ~(|aligned[W-1:OUT_WIDTH-1]);
  assign dout = fits ? aligned[OUT_WIDTH-1:0] : {aligned[W-1], {(OUT_WIDTH-1){~aligned[W-1]}}};
endmodule

// File: rtl/parallel_macc.sv
// parallel_macc: pipelined multi-lane signed MAC with per-frame saturating output
module parallel_macc
  import parallel_macc_pkg::*;
#(
  parameter int PARALLEL_IN = PARALLEL_IN_DEF,
  parameter int DATA1_WIDTH = DATA1_WIDTH_DEF,
  parameter int DATA1_INT = DATA1_INT_DEF,
  parameter int DATA2_WIDTH = DATA2_WIDTH_DEF,
  parameter int DATA2_INT = DATA2_INT_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
  parameter int DOUT_INT = DOUT_INT_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PARALLEL_IN*DATA1_WIDTH-1:0] din1,
  input  logic [PARALLEL_IN*DATA2_WIDTH-1:0] din2,
  input  logic                               en,
  input  logic                               last,
  output logic [DOUT_WIDTH-1:0]              dout,
  output logic                               dout_valid
);
  localparam int P = DATA1_WIDTH + DATA2_WIDTH;
  localparam int PF = P - DATA1_INT - DATA2_INT;
  localparam int S = P + clog2(PARALLEL_IN);
  localparam int A = S + ACC_WIDTH;
  localparam int OF = DOUT_WIDTH - DOUT_INT;
  logic signed [P-1:0] prod_c [PARALLEL_IN];
  logic signed [P-1:0] prod [PARALLEL_IN];
  logic signed [S-1:0] part [PARALLEL_IN+1];
  logic signed [S-1:0] sum;
  logic signed [A-1:0] acc;
  logic signed [A-1:0] total;
  logic [DOUT_WIDTH-1:0] cast_out;
  logic en_d1, last_d1, en_d2, last_d2;
  assign part[0] = '0;
  for (genvar i = 0; i < PARALLEL_IN; i++) begin : g_lane
    assign prod_c[i] = P'($signed(din1[i*DATA1_WIDTH +: DATA1_WIDTH])) *
                       P'($signed(din2[i*DATA2_WIDTH +: DATA2_WIDTH]));
    assign part[i+1] = part[i] + S'(prod[i]);
  end
  assign total = acc + A'(sum);
  // stage 1: lane products; last is folded with en so an unqualified last never propagates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod <= '{default: '0};
      en_d1 <= 1'b0;
      last_d1 <= 1'b0;
    end else begin
      prod <= prod_c;
      en_d1 <= en;
      last_d1 <= en & last;
    end
  end
  // stage 2: adder-tree sum of the registered products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
      en_d2 <= 1'b0;
      last_d2 <= 1'b0;
    end else begin
      sum <= part[PARALLEL_IN];
      en_d2 <= en_d1;
      last_d2 <= last_d1;
    end
  end
  signed_cast_sat #(
    .IN_WIDTH(A),
    .IN_FRAC(PF),
    .OUT_WIDTH(DOUT_WIDTH),
    .OUT_FRAC(OF)
  ) u_cast (
    .din(total),
    .dout(cast_out)
  );
  // stage 3: accumulate, and on the frame's last beat emit the converted total and clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= en_d2 & last_d2;
      if (en_d2) acc <= last_d2 ? '0 : total;
      if (en_d2 && last_d2) dout <= cast_out;
    end
  end
endmodule

// File: tb/tb_parallel_macc.sv
// tb_parallel_macc: directed self-checking bench for parallel_macc
module tb_parallel_macc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [63:0] din1 = '0;
  logic [63:0] din2 = '0;
  logic en = 1'b0;
  logic last = 1'b0;
  logic [31:0] dout;
  logic dout_valid;
  int checks = 0;
  int failures = 0;
  int vcount = 0;
  parallel_macc dut (
    .clk(clk),
    .rst(rst),
    .din1(din1),
    .din2(din2),
    .en(en),
    .last(last),
    .dout(dout),
    .dout_valid(dout_valid)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (dout_valid === 1'b1) vcount++;
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic l);
    @(negedge clk);
    din1 = {4{a}};
    din2 = {4{b}};
    en = 1'b1;
    last = l;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
      last = 1'b0;
    end
  endtask
  task automatic wait_valid(output int lat, output logic [31:0] v);
    lat = 0;
    v = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      en = 1'b0;
      last = 1'b0;
      if (dout_valid === 1'b1) begin
        lat = i;
        v = dout;
        break;
      end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=%h", dout, 32'h0); end
    checks++;
    if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    rst = 1'b1;
  endtask
  task automatic test_single;
    int lat;
    logic [31:0] v;
    beat(16'h4000, 16'h4000, 1'b1);
    wait_valid(lat, v);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", lat); end
    checks++;
    if (v !== 32'h0400_0000) begin failures++; $display("FAIL single_dout got=%h exp=%h", v, 32'h0400_0000); end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0) begin failures++; $display("FAIL single_strobe_width got=%b exp=0", dout_valid); end
  endtask
  task automatic test_gaps;
    int lat;
    int v0;
    logic [31:0] v;
    v0 = vcount;
    beat(16'h4000, 16'h4000, 1'b0);
    idle(2);
    beat(16'h4000, 16'h4000, 1'b0);
    idle(1);
    beat(16'h4000, 16'h4000, 1'b1);
    wait_valid(lat, v);
    checks++;
    if (v !== 32'h0C00_0000) begin failures++; $display("FAIL gaps_dout got=%h exp=%h", v, 32'h0C00_0000); end
    idle(3);
    checks++;
    if (vcount - v0 !== 1) begin failures++; $display("FAIL gaps_strobes got=%0d exp=1", vcount - v0); end
    checks++;
    if (dout !== 32'h0C00_0000) begin failures++; $display("FAIL gaps_hold got=%h exp=%h", dout, 32'h0C00_0000); end
  endtask
  task automatic test_negative;
    int lat;
    logic [31:0] v;
    beat(16'hC000, 16'h2000, 1'b1);
    wait_valid(lat, v);
    checks++;
    if (v !== 32'hFE00_0000) begin failures++; $display("FAIL negative_dout got=%h exp=%h", v, 32'hFE00_0000); end
  endtask
  task automatic test_saturation;
    int lat;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) beat(16'h8000, 16'h8000, i == 7);
    wait_valid(lat, v);
    checks++;
    if (v !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sat_max got=%h exp=%h", v, 32'h7FFF_FFFF); end
    for (int i = 0; i < 8; i++) beat(16'h8000, 16'h7FFF, i == 7);
    wait_valid(lat, v);
    checks++;
    if (v !== 32'h8001_0000) begin failures++; $display("FAIL near_min got=%h exp=%h", v, 32'h8001_0000); end
    for (int i = 0; i < 9; i++) beat(16'h8000, 16'h7FFF, i == 8);
    wait_valid(lat, v);
    checks++;
    if (v !== 32'h8000_0000) begin failures++; $display("FAIL sat_min got=%h exp=%h", v, 32'h8000_0000); end
  endtask
  task automatic test_back_to_back;
    int lat;
    int v0;
    logic [31:0] v;
    beat(16'h4000, 16'h4000, 1'b1);
    beat(16'h2000, 16'h4000, 1'b1);
    wait_valid(lat, v);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=2", lat); end
    checks++;
    if (v !== 32'h0400_0000) begin failures++; $display("FAIL b2b_first got=%h exp=%h", v, 32'h0400_0000); end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'h0200_0000) begin
      failures++;
      $display("FAIL b2b_second got=%b/%h exp=1/%h", dout_valid, dout, 32'h0200_0000);
    end
    idle(3);
    v0 = vcount;
    beat(16'h4000, 16'h4000, 1'b0);
    @(negedge clk);
    en = 1'b0;
    last = 1'b1;
    idle(4);
    checks++;
    if (vcount - v0 !== 0) begin failures++; $display("FAIL last_no_en_strobes got=%0d exp=0", vcount - v0); end
    beat(16'h4000, 16'h4000, 1'b1);
    wait_valid(lat, v);
    checks++;
    if (v !== 32'h0800_0000) begin failures++; $display("FAIL last_no_en_frame got=%h exp=%h", v, 32'h0800_0000); end
  endtask
  task automatic test_reset_mid;
    int lat;
    logic [31:0] v;
    beat(16'h4000, 16'h4000, 1'b0);
    beat(16'h4000, 16'h4000, 1'b0);
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h/%b exp=0/0", dout, dout_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    beat(16'h4000, 16'h4000, 1'b1);
    wait_valid(lat, v);
    checks++;
    if (v !== 32'h0400_0000) begin failures++; $display("FAIL reset_mid_frame got=%h exp=%h", v, 32'h0400_0000); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_gaps;
    test_negative;
    test_saturation;
    test_back_to_back;
    test_reset_mid;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
